// File: rtl/imm_extend_pipe.sv
// ----------------------------------------------------------------------------
// imm_extend_pipe
//   Two-stage pipelined immediate extender for the 32-bit ARM-subset datapath.
//   It sits between decode and execute and has valid/ready handshaking on both
//   sides. Latency is fixed at two cycles, and it sustains one item per cycle.
//
// Parameters
//   WIDTH  : width of the extended immediate (legal range 26..64)
//   CNT_W  : width of the saturating illegal-mode counter
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   Instr/ImmSrc valid this cycle
//   in_ready     out  block accepts input this cycle (combinational from out_ready)
//   Instr        in   instruction bits [23:0]
//   ImmSrc       in   extension mode
//   out_valid    out  ExtImm/ShCarry/ImmErr valid
//   out_ready    in   consumer accepts output this cycle
//   ExtImm       out  extended immediate
//   ShCarry      out  shifter carry-out of the rotated immediate (mode 011 only)
//   ImmErr       out  result came from an illegal ImmSrc
//   illegal_cnt  out  saturating count of accepted illegal-mode transfers
// ----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      Instr,
    input  logic [2:0]       ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ExtImm,
    output logic             ShCarry,
    output logic             ImmErr,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        IMM_ZX8  = 3'b000,
        IMM_ZX12 = 3'b001,
        IMM_BR   = 3'b010,
        IMM_ROT  = 3'b011,
        IMM_SX12 = 3'b100
    } imm_mode_e;

    // Stage S1: pre-rotation value, raw rotate amount, error flag
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_val;
    logic [4:0]       r_s1_amt;
    logic             r_s1_err;

    // Stage S2: final result, drives the outputs
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_imm;
    logic             r_s2_carry;
    logic             r_s2_err;

    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_adv;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_pre;
    logic [4:0]       w_amt;
    logic             w_err;
    logic [6:0]       w_amt_ext;
    logic [6:0]       w_eff;
    logic [WIDTH-1:0] w_rot;
    logic             w_carry;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer = in_valid && in_ready;

    // S1 decode: build the unrotated value for each mode
    always_comb begin
        w_pre = '0;
        w_amt = '0;
        w_err = 1'b0;
        case (ImmSrc)
            IMM_ZX8:  w_pre[7:0] = Instr[7:0];
            IMM_ZX12: w_pre[11:0] = Instr[11:0];
            IMM_BR: begin
                w_pre       = {WIDTH{Instr[23]}};
                w_pre[25:0] = {Instr, 2'b00};
            end
            IMM_ROT: begin
                w_pre[7:0] = Instr[7:0];
                w_amt      = {Instr[11:8], 1'b0};
            end
            IMM_SX12: begin
                w_pre       = {WIDTH{Instr[11]}};
                w_pre[11:0] = Instr[11:0];
            end
            default: w_err = 1'b1;
        endcase
    end

    // S2 rotate. The amount can reach 30, which exceeds narrow WIDTHs, so it
    // is reduced modulo WIDTH (a single subtraction suffices for WIDTH >= 26).
    // A zero effective amount makes the left shift equal WIDTH, giving zero.
    // Carry follows the raw amount, not the reduced one.
    always_comb begin
        w_amt_ext = {2'b00, r_s1_amt};
        w_eff     = w_amt_ext;
        if (w_amt_ext >= 7'(WIDTH)) begin
            w_eff = w_amt_ext - 7'(WIDTH);
        end
        w_rot   = (r_s1_val >> w_eff) | (r_s1_val << (7'(WIDTH) - w_eff));
        w_carry = (r_s1_amt != 5'd0) ? w_rot[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_amt   <= '0;
            r_s1_err   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_imm   <= '0;
            r_s2_carry <= 1'b0;
            r_s2_err   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_val <= w_pre;
                    r_s1_amt <= w_amt;
                    r_s1_err <= w_err;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_imm   <= w_rot;
                    r_s2_carry <= w_carry;
                    r_s2_err   <= r_s1_err;
                end
            end
            if (w_in_xfer && w_err && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign ExtImm      = r_s2_imm;
    assign ShCarry     = r_s2_carry;
    assign ImmErr      = r_s2_err;
    assign illegal_cnt = r_cnt;

endmodule
